// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 line driver and its delay line.
// Optional build macro used by the driver: HUB75_BRIGHTNESS_EN.
package hub75_pkg;

    localparam int COLS_W         = 6;
    localparam int ADDR_W         = 5;
    localparam int RGB_W          = 3;
    localparam int BLANK_PRE_DEF  = 2;
    localparam int BLANK_POST_DEF = 2;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } line_state_e;

    // Successor of a column index with an explicit wrap, so COLS need not be a power of 2.
    function automatic logic [COLS_W-1:0] col_next(input logic [COLS_W-1:0] c, input int cols);
        return (c == COLS_W'(cols - 1)) ? '0 : c + COLS_W'(1);
    endfunction

endpackage

// File: rtl/hub75_delay_line.sv
// DEPTH-stage register chain that aligns the column/address stream with
// the framebuffer read data. Cleared to zero by reset.
module hub75_delay_line #(
    parameter int W     = 12,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [DEPTH-1:0][W-1:0] stage_q;
    logic [DEPTH-1:0][W-1:0] stage_d;

    always_comb begin
        stage_d    = '0;
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/hub75_line_driver.sv
// Turns the scan column/address stream plus framebuffer pixels into HUB75 pins.
// Define HUB75_BRIGHTNESS_EN to add the per-line 'bright' OE window input.
module hub75_line_driver
    import hub75_pkg::*;
#(
    parameter int COLS       = 64,
    parameter int RD_LAT     = 1,
    parameter int BLANK_PRE  = BLANK_PRE_DEF,
    parameter int BLANK_POST = BLANK_POST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [COLS_W-1:0] col,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [RGB_W-1:0]  pix_top,
    input  logic [RGB_W-1:0]  pix_bot,
`ifdef HUB75_BRIGHTNESS_EN
    input  logic [COLS_W-1:0] bright,
`endif
    output logic              hub_clk_en,
    output logic              hub_lat,
    output logic              hub_oe_n,
    output logic [RGB_W-1:0]  hub_rgb_top,
    output logic [RGB_W-1:0]  hub_rgb_bot,
    output logic [ADDR_W-1:0] hub_addr,
    output logic              sync_lost,
    output logic [1:0]        state_dbg
);

    localparam int DL_W = 1 + ADDR_W + COLS_W;

    // A valid bit travels with dc/da so the cleared delay line is never mistaken for column 0.
    logic [DL_W-1:0]   dl_out;
    logic              dv;
    logic [ADDR_W-1:0] da;
    logic [COLS_W-1:0] dc;

    hub75_delay_line #(
        .W     (DL_W),
        .DEPTH (RD_LAT)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  ({1'b1, addr_in, col}),
        .dout (dl_out)
    );

    assign {dv, da, dc} = dl_out;

    line_state_e       state_q, state_d;
    logic [COLS_W-1:0] prev_q, prev_d;
    logic              clk_en_q, clk_en_d;
    logic              lat_q, lat_d;
    logic              oe_n_q, oe_n_d;
    logic [RGB_W-1:0]  rgb_top_q, rgb_top_d;
    logic [RGB_W-1:0]  rgb_bot_q, rgb_bot_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              sync_lost_q, sync_lost_d;

    logic seq_ok;
    logic blank_edge;
    logic window_on;
    logic shift_en;
    logic run_en;

    assign seq_ok     = (dc == col_next(prev_q, COLS));
    assign blank_edge = (dc >= COLS_W'(COLS - BLANK_PRE)) || (dc < COLS_W'(BLANK_POST));

`ifdef HUB75_BRIGHTNESS_EN
    logic [COLS_W-1:0] bright_q, bright_d;
    logic [COLS_W-1:0] bright_cur;
    logic [COLS_W:0]   bright_lim;

    // The value sampled at dc==0 governs the whole line, including that first cycle.
    always_comb begin
        bright_d   = (dv && dc == '0) ? bright : bright_q;
        bright_cur = (dc == '0) ? bright : bright_q;
        bright_lim = (COLS_W+1)'(bright_cur) + (COLS_W+1)'(BLANK_POST);
        window_on  = !blank_edge && ({1'b0, dc} < bright_lim);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bright_q <= '0;
        end else begin
            bright_q <= bright_d;
        end
    end
`else
    assign window_on = !blank_edge;
`endif

    always_comb begin
        state_d     = state_q;
        prev_d      = dv ? dc : prev_q;
        clk_en_d    = 1'b0;
        lat_d       = 1'b0;
        oe_n_d      = 1'b1;
        rgb_top_d   = '0;
        rgb_bot_d   = '0;
        addr_d      = (dv && dc == '0) ? da : addr_q;
        sync_lost_d = 1'b0;
        shift_en    = 1'b0;
        run_en      = 1'b0;

        // The state change takes effect in the same cycle as the dc that causes it,
        // so pixel 0 of the priming line is shifted and the first LAT lands on dc==0.
        case (state_q)
            SYNC: begin
                if (dv && dc == '0) begin
                    state_d  = PRIME;
                    shift_en = 1'b1;
                end
            end
            PRIME: begin
                if (!seq_ok) begin
                    state_d     = SYNC;
                    sync_lost_d = 1'b1;
                end else if (dc == '0) begin
                    state_d  = RUN;
                    shift_en = 1'b1;
                    run_en   = 1'b1;
                end else begin
                    shift_en = 1'b1;
                end
            end
            RUN: begin
                if (!seq_ok) begin
                    state_d     = SYNC;
                    sync_lost_d = 1'b1;
                end else begin
                    shift_en = 1'b1;
                    run_en   = 1'b1;
                end
            end
            default: state_d = SYNC;
        endcase

        if (shift_en) begin
            clk_en_d  = 1'b1;
            rgb_top_d = pix_top;
            rgb_bot_d = pix_bot;
        end
        if (run_en) begin
            lat_d  = (dc == '0);
            oe_n_d = !window_on;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SYNC;
            prev_q      <= '0;
            clk_en_q    <= 1'b0;
            lat_q       <= 1'b0;
            oe_n_q      <= 1'b1;
            rgb_top_q   <= '0;
            rgb_bot_q   <= '0;
            addr_q      <= '0;
            sync_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            clk_en_q    <= clk_en_d;
            lat_q       <= lat_d;
            oe_n_q      <= oe_n_d;
            rgb_top_q   <= rgb_top_d;
            rgb_bot_q   <= rgb_bot_d;
            addr_q      <= addr_d;
            sync_lost_q <= sync_lost_d;
        end
    end

    assign hub_clk_en  = clk_en_q;
    assign hub_lat     = lat_q;
    assign hub_oe_n    = oe_n_q;
    assign hub_rgb_top = rgb_top_q;
    assign hub_rgb_bot = rgb_bot_q;
    assign hub_addr    = addr_q;
    assign sync_lost   = sync_lost_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_hub75_line_driver.sv
// Bench for hub75_line_driver (COLS=64, RD_LAT=1, BLANK_PRE=BLANK_POST=2).
// Build with +define+HUB75_BRIGHTNESS_EN to also exercise the brightness window.
module tb_hub75_line_driver;
    import hub75_pkg::*;

    localparam int COLS = 64;
    localparam int BPRE = 2;
    localparam int BPOST = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] col;
    logic [4:0] addr_in;
    logic [2:0] pix_top, pix_bot;
    logic [5:0] bright_in;
    logic       hub_clk_en, hub_lat, hub_oe_n, sync_lost;
    logic [2:0] hub_rgb_top, hub_rgb_bot;
    logic [4:0] hub_addr;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    hub75_line_driver #(
        .COLS       (COLS),
        .RD_LAT     (1),
        .BLANK_PRE  (BPRE),
        .BLANK_POST (BPOST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .col         (col),
        .addr_in     (addr_in),
        .pix_top     (pix_top),
        .pix_bot     (pix_bot),
`ifdef HUB75_BRIGHTNESS_EN
        .bright      (bright_in),
`endif
        .hub_clk_en  (hub_clk_en),
        .hub_lat     (hub_lat),
        .hub_oe_n    (hub_oe_n),
        .hub_rgb_top (hub_rgb_top),
        .hub_rgb_bot (hub_rgb_bot),
        .hub_addr    (hub_addr),
        .sync_lost   (sync_lost),
        .state_dbg   (state_dbg)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int lost_seen = 0;

    // {sync_lost, clk_en, lat, oe_n, rgb_top, rgb_bot, addr}
    logic [14:0] exp_q[$];
    localparam logic [14:0] RST_VEC = {1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 5'd0};

    // Reference model: number of in-sequence line starts seen since the last sync event.
    int         m_lines;
    int         m_prev;
    logic [4:0] m_addr;
    int         m_bright;
    logic [2:0] pend_top, pend_bot;

    task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic sample();
        logic [14:0] e;
        if (sync_lost === 1'b1) lost_seen++;
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            check("pins", {sync_lost, hub_clk_en, hub_lat, hub_oe_n,
                           hub_rgb_top, hub_rgb_bot, hub_addr}, e);
        end
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            sample();
            rst = 1'b1;
            exp_q.delete();
            exp_q.push_back(RST_VEC);
            exp_q.push_back(RST_VEC);
        end
        m_lines = 0;
        m_prev  = 0;
        m_addr  = '0;
    endtask

    task automatic drive(input int c, input logic [4:0] a, input logic [2:0] pt, input logic [2:0] pb);
        logic       lost;
        logic       on;
        logic [14:0] e;
        @(negedge clk);
        sample();
        rst     = 1'b0;
        col     = 6'(c);
        addr_in = a;
        pix_top = pend_top;
        pix_bot = pend_bot;
        pend_top = pt;
        pend_bot = pb;

        lost = 1'b0;
        if (m_lines > 0 && c != (m_prev + 1) % COLS) begin
            m_lines = 0;
            lost    = 1'b1;
        end else if (c == 0 && m_lines < 2) begin
            m_lines++;
        end
        if (c == 0) begin
            m_addr   = a;
            m_bright = int'(bright_in);
        end
        m_prev = c;

        on = (c >= BPOST) && (c < COLS - BPRE) && (c < BPOST + m_bright);
        if (lost)
            e = {1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, m_addr};
        else if (m_lines == 0)
            e = {1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, m_addr};
        else if (m_lines == 1)
            e = {1'b0, 1'b1, 1'b0, 1'b1, pt, pb, m_addr};
        else
            e = {1'b0, 1'b1, (c == 0), !on, pt, pb, m_addr};
        exp_q.push_back(e);
    endtask

    task automatic run_cols(input int first, input int last, input logic [4:0] a);
        for (int c = first; c <= last; c++) begin
            if (c == 10)
                drive(c, a, 3'b101, 3'($urandom_range(0, 7)));
            else
                drive(c, a, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
    endtask

    initial begin
        int lost_before;
        rst = 1'b1; col = '0; addr_in = '0; pix_top = '0; pix_bot = '0;
        pend_top = '0; pend_bot = '0; bright_in = 6'd63; m_bright = 63;
        m_lines = 0; m_prev = 0; m_addr = '0;

        do_reset(3);
        check1("rst_clk_en", hub_clk_en, 1'b0);
        check1("rst_lat", hub_lat, 1'b0);
        check1("rst_oe_n", hub_oe_n, 1'b1);
        check("rst_rgb_addr", {7'd0, hub_rgb_top, hub_rgb_bot, hub_addr}, 15'd0);
        check1("rst_sync_lost", sync_lost, 1'b0);
        check("rst_state", {13'd0, state_dbg}, {13'd0, 2'(SYNC)});

        // Sync, prime, then steady run with an address change at a line start.
        run_cols(0, 63, 5'd5);
        run_cols(0, 63, 5'd5);
        run_cols(0, 63, 5'd5);
        run_cols(0, 63, 5'd6);
        run_cols(0, 63, 5'd6);

        // Column stream jumps 20 -> 25 in RUN.
        lost_before = lost_seen;
        run_cols(0, 20, 5'd6);
        run_cols(25, 63, 5'd6);
        run_cols(0, 63, 5'd7);
        run_cols(0, 63, 5'd7);
        check("sync_lost_pulses", 15'(lost_seen - lost_before), 15'd1);

        // One-cycle reset mid-line, then recovery through SYNC/PRIME.
        run_cols(0, 29, 5'd7);
        do_reset(1);
        run_cols(31, 63, 5'd3);
        run_cols(0, 63, 5'd3);
        run_cols(0, 63, 5'd4);
        run_cols(0, 63, 5'd4);

`ifdef HUB75_BRIGHTNESS_EN
        bright_in = 6'd10;
        run_cols(0, 63, 5'd1);
        bright_in = 6'd0;
        run_cols(0, 63, 5'd2);
        bright_in = 6'd63;
        run_cols(0, 63, 5'd3);
        bright_in = 6'd59;
        run_cols(0, 63, 5'd4);
`endif

        run_cols(0, 3, 5'd4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
